// File: rtl/xor_response_checker_pkg.sv
// Shared types and helpers for the XOR response checker: FSM state encoding,
// reference parity and a width-agnostic saturating increment.
package xor_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_INPUTS = 8;
  localparam int unsigned MAX_CNT_W  = 32;

  // Callers zero-extend narrower vectors; the extra zeros leave parity unchanged.
  function automatic logic parity_of(input logic [MAX_INPUTS-1:0] v);
    return ^v;
  endfunction

  // Increments v unless it already sits at 2^w-1; w may be anything up to 32.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned         w);
    logic [MAX_CNT_W:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) begin
      return v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/xor_response_checker_if.sv
// Stimulus/response pair handshake between the XOR stimulus side and the checker.
interface xor_response_checker_if #(
  parameter int unsigned N_INPUTS = 5
) ();

  logic                vec_valid;
  logic [N_INPUTS-1:0] vec_i;
  logic                duv_o;
  logic                vec_ready;

  modport master (
    output vec_valid,
    output vec_i,
    output duv_o,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_i,
    input  duv_o,
    output vec_ready
  );

endinterface

// File: rtl/xor_response_checker_cov_tracker.sv
// Coverage bitmap over all 2^N_INPUTS vectors: set on accept, cleared on start.
module xor_cov_tracker #(
  parameter int unsigned N_INPUTS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                set_en,
  input  logic [N_INPUTS-1:0] set_idx,
  output logic                completes,
  output logic                all_covered
);

  localparam int unsigned N_VEC = 1 << N_INPUTS;

  logic [N_VEC-1:0] cov_q;
  logic [N_VEC-1:0] cov_d;
  logic             all_covered_q;
  logic             all_covered_d;

  always_comb begin
    cov_d = cov_q;
    if (clear) begin
      cov_d = '0;
    end else if (set_en) begin
      cov_d[set_idx] = 1'b1;
    end
    all_covered_d = &cov_d;
  end

  // Looking at the next bitmap lets the owner leave RUN on the final accept edge.
  assign completes   = set_en & all_covered_d;
  assign all_covered = all_covered_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cov_q         <= '0;
      all_covered_q <= 1'b0;
    end else begin
      cov_q         <= cov_d;
      all_covered_q <= all_covered_d;
    end
  end

endmodule

// File: rtl/xor_response_checker.sv
// Captures XOR device stimulus/response pairs, checks against reference parity,
// counts mismatches and finishes once every input vector has been seen.
module xor_response_checker
  import xor_check_pkg::*;
#(
  parameter int unsigned N_INPUTS = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  xor_response_checker_if.slave  vif,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       vec_count,
  output logic                   first_fail_valid,
  output logic [N_INPUTS-1:0]    first_fail_vec
);

  state_e              state_q, state_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CNT_W-1:0]    vec_count_q, vec_count_d;
  logic                ffv_q, ffv_d;
  logic [N_INPUTS-1:0] ffvec_q, ffvec_d;

  logic accept;
  logic expected;
  logic mismatch;
  logic cov_completes;
  logic all_covered;

  assign vif.vec_ready = (state_q == RUN) & ~start;
  assign accept        = vif.vec_valid & vif.vec_ready;

  xor_cov_tracker #(
    .N_INPUTS (N_INPUTS)
  ) u_cov (
    .clk         (clk),
    .rst         (rst),
    .clear       (start),
    .set_en      (accept),
    .set_idx     (vif.vec_i),
    .completes   (cov_completes),
    .all_covered (all_covered)
  );

  always_comb begin
    expected    = parity_of(MAX_INPUTS'(vif.vec_i));
    mismatch    = vif.duv_o ^ expected;
    state_d     = state_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    ffv_d       = ffv_q;
    ffvec_d     = ffvec_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (cov_completes) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // start wins over accept: vec_ready is low whenever start is high.
    if (start) begin
      pass_d      = 1'b0;
      err_count_d = '0;
      vec_count_d = '0;
      ffv_d       = 1'b0;
      ffvec_d     = '0;
    end else if (accept) begin
      vec_count_d = CNT_W'(sat_inc(MAX_CNT_W'(vec_count_q), CNT_W));
      if (mismatch) begin
        err_count_d = CNT_W'(sat_inc(MAX_CNT_W'(err_count_q), CNT_W));
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vif.vec_i;
        end
      end
      if (cov_completes) begin
        pass_d = (err_count_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      vec_count_q <= '0;
      ffv_q       <= 1'b0;
      ffvec_q     <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      ffv_q       <= ffv_d;
      ffvec_q     <= ffvec_d;
    end
  end

  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE) & all_covered;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign vec_count        = vec_count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: doc/xor_response_checker.md
Name: xor_response_checker

Overview:
- Response-side companion to the XOR gate stimulus benches. Stimulus drives vectors into an XORn_E device; this block captures the vector and the device output, compares the output against the reference parity, and counts mismatches.
- Tracks which of the 2^N_INPUTS vectors have been seen. Declares completion when coverage is exhaustive.
- Synthesisable, so it serves both simulation and on-board self-test of the XOR2/3/5 family.

Parameters:
- N_INPUTS, 5, width of the applied vector. Legal range 2..8.
- CNT_W, 16, width of the error and vector counters.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Clears all results and begins a check run.
- vec_valid  in  1  vec_i/duv_o hold a settled stimulus/response pair.
- vec_i  in  N_INPUTS  applied vector; bit 0 = i1, bit N-1 = iN.
- duv_o  in  1  observed output o of the device under verification.
- vec_ready  out  1  checker accepts a pair this cycle.
- busy  out  1  run in progress.
- done  out  1  run finished; all vectors covered.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  CNT_W  mismatches this run, saturating.
- vec_count  out  CNT_W  pairs accepted this run, saturating.
- first_fail_valid  out  1  at least one mismatch has been captured.
- first_fail_vec  out  N_INPUTS  vector of the first mismatch.

Behaviour:
- Reset values (rst=1 at an edge): state IDLE; busy, done, pass and first_fail_valid = 0; err_count, vec_count and first_fail_vec = 0; coverage bitmap (2^N_INPUTS bits) = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - vec_ready = 0; vec_valid is ignored.
  - start moves to RUN.
- Entering RUN from any state via start: err_count, vec_count, coverage, first_fail_valid and first_fail_vec all clear in the same edge.
- RUN:
  - busy = 1.
  - vec_ready = ~start (combinational). Accept condition is vec_valid & vec_ready.
- Per accepted pair, all updates registered and visible one cycle after acceptance:
  - expected = XOR-reduce of vec_i.
  - mismatch = duv_o ^ expected.
  - vec_count increments.
  - On mismatch, err_count increments.
  - On mismatch with first_fail_valid=0, first_fail_vec ← vec_i and first_fail_valid ← 1.
  - Coverage bit at index vec_i is set.
- Duplicate vectors: checked and counted in vec_count; coverage is unchanged.
- Saturation: both counters stop at 2^CNT_W-1 and never wrap.
- RUN→DONE: on the edge where an accepted pair sets the last unset coverage bit. That pair's compare result is included in the final counts.
  - done and pass are valid from the next cycle.
  - pass = (err_count==0), held stable.
- DONE:
  - done = 1, busy = 0, vec_ready = 0.
  - All results hold until start or rst.
  - start moves to RUN with a clear.
- start during RUN: restart. Counters and coverage clear. A pair presented in the same cycle is dropped, because vec_ready=0.
- rst mid-run: immediate return to the reset values. The partial run is discarded.
- X on vec_i/duv_o while vec_valid=0 must not affect state.

Decomposition:
- Shared package xor_check_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the function for the expected parity of a vector;
  - a saturating-increment function usable for any width.
- One natural sub-module: xor_cov_tracker. It owns the 2^N bitmap, the set-on-accept logic, clear-on-start, and a registered all_covered flag computed combinationally from the next bitmap value, so the transition happens on the same edge as the final accept.

Test Plan:
- N_INPUTS=5, rst then start, then 32 ascending vectors with correct duv_o, one per cycle. Required: done=1 the cycle after vector 31, pass=1, err_count=0, vec_count=32, first_fail_valid=0.
- As above, but duv_o=0 at vec_i=5'b00111 (expected 1) and duv_o=1 at 5'b00011 (expected 0). Required: err_count=2, first_fail_vec=5'b00011 (applied first in ascending order), pass=0.
- N_INPUTS=3: apply 3'b000 three times, then all 8 vectors. Required: vec_count=11, done asserts only after the 8th distinct vector.
- After 10 vectors, start pulses together with vec_valid. Required: vec_ready=0 that cycle, all counters read 0 the next cycle, busy stays 1.
- rst=1 for one cycle mid-run. Required: IDLE, all outputs zero, vec_valid ignored until the next start.
- CNT_W=2, N_INPUTS=2, all 4 vectors with inverted duv_o plus 2 duplicates. Required: err_count and vec_count saturate at 3, pass=0.
